weight_fetch_seq: RTL and testbench

//  Read sequencer placed directly downstream of the weight SRAM. One start

---
 rtl/weight_fetch_seq.sv | 175 +++++++++++++++++
 tb/tb_weight_fetch_seq.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_fetch_seq.sv
// weight_fetch_seq: read sequencer between the weight SRAM and the MAC datapath.
// One start command reads a run of weights (address wraps DEPTH-1 -> 0), absorbs
// the SRAM's 1-cycle registered read latency and streams the words through a
// 3-entry output FIFO on a valid/ready interface at up to 1 word per cycle.
// Optional build macro: WFETCH_BOUNDS_CHECK_EN adds an err port and refuses
// out-of-range commands.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | waiting for start; latches base/length on start
// S_FETCH | issuing one read per cycle while the FIFO has room
// S_DRAIN | all reads issued; waiting for the final handshake
module weight_fetch_seq #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 2000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] length,
    output logic              busy,
    output logic              done,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    input  logic [DATA_W-1:0] sram_q,
    output logic [DATA_W-1:0] w_data,
    output logic              w_valid,
    input  logic              w_ready,
    output logic              w_last
`ifdef WFETCH_BOUNDS_CHECK_EN
    ,
    output logic              err
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] rd_left_q, rd_left_d;
    logic [ADDR_W-1:0] out_left_q, out_left_d;
    logic              pend1_q, pend1_d;
    logic              pend2_q;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [DATA_W-1:0] fifo_q [3];
    logic [1:0]        wr_ptr_q, rd_ptr_q, cnt_q;

    logic              push, pop, room, reject;
    logic [2:0]        occ;
    logic [ADDR_W-1:0] addr_inc;

    // pend1: address on the SRAM bus this cycle; pend2: its data is on sram_q now
    assign push = pend2_q;
    assign pop  = (cnt_q != 2'd0) && w_ready;
    assign occ  = {2'b00, pend1_q} + {2'b00, pend2_q} + {1'b0, cnt_q};
    // A slot freed by this cycle's handshake may be reused at the same edge.
    // w_ready only reaches flop D inputs, never sram_addr combinationally.
    assign room = (occ < 3'd3) || pop;
    assign addr_inc = (addr_q == ADDR_W'(DEPTH - 1)) ? '0 : addr_q + 1'b1;

`ifdef WFETCH_BOUNDS_CHECK_EN
    // runs that would wrap past the last word are refused as well
    assign reject = (32'(base_addr) >= 32'(DEPTH)) || (32'(length) > 32'(DEPTH)) ||
                    ((32'(base_addr) + 32'(length)) > 32'(DEPTH));
    assign err    = err_q;
`else
    assign reject = 1'b0;
`endif

    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign sram_we   = 1'b0;
    assign sram_addr = addr_q;
    assign w_valid   = (cnt_q != 2'd0);
    assign w_data    = fifo_q[rd_ptr_q];
    assign w_last    = w_valid && (out_left_q == ADDR_W'(1));

    // Next-state, read-issue and completion decisions
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rd_left_d  = rd_left_q;
        out_left_d = pop ? out_left_q - 1'b1 : out_left_q;
        pend1_d    = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (reject) begin
                        err_d = 1'b1;
                    end else if (length == '0) begin
                        done_d = 1'b1;
                    end else begin
                        addr_d     = base_addr;
                        pend1_d    = 1'b1;
                        rd_left_d  = length - 1'b1;
                        out_left_d = length;
                        state_d    = (length == ADDR_W'(1)) ? S_DRAIN : S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                if (room) begin
                    addr_d    = addr_inc;
                    pend1_d   = 1'b1;
                    rd_left_d = rd_left_q - 1'b1;
                    if (rd_left_q == ADDR_W'(1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (pop && (out_left_q == ADDR_W'(1))) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Sequencer state, address and counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            rd_left_q  <= '0;
            out_left_q <= '0;
            pend1_q    <= 1'b0;
            pend2_q    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rd_left_q  <= rd_left_d;
            out_left_q <= out_left_d;
            pend1_q    <= pend1_d;
            pend2_q    <= pend1_q;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // Output FIFO capturing sram_q one cycle after each issued address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            cnt_q    <= 2'd0;
            for (int i = 0; i < 3; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= sram_q;
                wr_ptr_q         <= (wr_ptr_q == 2'd2) ? 2'd0 : wr_ptr_q + 2'd1;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == 2'd2) ? 2'd0 : rd_ptr_q + 2'd1;
            end
            cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_weight_fetch_seq.sv
// Testbench for weight_fetch_seq: behavioural stream model checked every cycle,
// plus directed literal expectations.
`timescale 1ns/1ps
module tb_weight_fetch_seq;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 12;
    localparam int DEPTH  = 2000;
`ifdef WFETCH_BOUNDS_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              start = 1'b0;
    logic              w_ready = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W-1:0] length = '0;
    logic              busy, done, sram_we, w_valid, w_last;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_q, w_data;
`ifdef WFETCH_BOUNDS_CHECK_EN
    logic              err;
`endif

    logic [DATA_W-1:0] sram [0:4095];
    int n_cmp = 0;
    int n_bad = 0;

    weight_fetch_seq #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .length(length),
        .busy(busy), .done(done), .sram_we(sram_we), .sram_addr(sram_addr), .sram_q(sram_q),
        .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready), .w_last(w_last)
`ifdef WFETCH_BOUNDS_CHECK_EN
        , .err(err)
`endif
    );

    always #5 clk = ~clk;

    // registered-read SRAM model
    always @(posedge clk) sram_q <= sram[sram_addr];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit tb_reject(int b, int l);
        return CHK_EN && ((b >= DEPTH) || (l > DEPTH) || (b + l > DEPTH));
    endfunction

    // model state
    bit  m_busy = 0, m_done_now = 0, m_err_now = 0, m_cyc1 = 0, hold = 0;
    int  m_base = 0, m_len = 0, m_acc = 0, m_iss = 0;
    logic [ADDR_W-1:0] prev_addr = '0;
    logic [DATA_W-1:0] hold_data = '0;
    logic              hold_last = 1'b0;
    int  rel_cyc = 0, first_valid_cyc = -1, last_cyc = -1, done_cyc = -1, n_done_seen = 0;
    int  got_q[$];
    int  addr_log[$];

    // per-cycle comparison against the stream model
    always @(negedge clk) begin
        bit hs, nb, nd, ne, nc1;
        if (!rst_n) begin
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_valid", w_valid, 0);
            chk("rst_last", w_last, 0);
            chk("rst_addr", sram_addr, 0);
            chk("rst_data", w_data, 0);
            chk("rst_we", sram_we, 0);
            m_busy = 0; m_done_now = 0; m_err_now = 0; m_cyc1 = 0; hold = 0;
            m_acc = 0; m_iss = 0; prev_addr = '0;
        end else begin
            rel_cyc++;
            chk("busy", busy, m_busy);
            chk("done", done, m_done_now);
            chk("sram_we", sram_we, 0);
`ifdef WFETCH_BOUNDS_CHECK_EN
            chk("err", err, m_err_now);
`endif
            if (done) begin
                n_done_seen++;
                if (done_cyc < 0) done_cyc = rel_cyc;
            end
            if (hold) begin
                chk("hold_valid", w_valid, 1);
                chk("hold_data", w_data, hold_data);
                chk("hold_last", w_last, hold_last);
            end
            if (!m_busy) begin
                chk("valid_idle", w_valid, 0);
            end else if (w_valid) begin
                if (first_valid_cyc < 0) first_valid_cyc = rel_cyc;
                if (w_last && last_cyc < 0) last_cyc = rel_cyc;
                chk("w_data", w_data, sram[(m_base + m_acc) % DEPTH]);
                chk("w_last", w_last, (m_acc == m_len - 1));
            end
            if (m_cyc1) begin
                m_iss = 1;
                chk("addr_first", sram_addr, m_base);
                addr_log.push_back(int'(sram_addr));
            end else if (m_busy && sram_addr !== prev_addr) begin
                chk("addr_seq", sram_addr, (m_base + m_iss) % DEPTH);
                m_iss++;
                addr_log.push_back(int'(sram_addr));
            end
            if (m_busy) begin
                chk("issued_le_len", (m_iss <= m_len), 1);
                chk("occupancy_le_3", ((m_iss - m_acc) <= 3), 1);
            end
            hs = w_valid && w_ready && m_busy;
            hold = w_valid && !w_ready;
            hold_data = w_data;
            hold_last = w_last;
            if (hs) begin
                got_q.push_back(int'($signed(w_data)));
                m_acc++;
            end
            nb = m_busy; nd = 0; ne = 0; nc1 = 0;
            if (hs && m_acc == m_len) begin
                nb = 0; nd = 1;
            end
            if (start && !m_busy) begin
                if (tb_reject(int'(base_addr), int'(length))) begin
                    ne = 1;
                end else begin
                    m_base = int'(base_addr); m_len = int'(length); m_acc = 0; m_iss = 0;
                    rel_cyc = 0; first_valid_cyc = -1; last_cyc = -1; done_cyc = -1;
                    got_q.delete(); addr_log.delete();
                    if (length == '0) nd = 1;
                    else begin nb = 1; nc1 = 1; end
                end
            end
            m_busy = nb; m_done_now = nd; m_err_now = ne; m_cyc1 = nc1;
            prev_addr = sram_addr;
        end
    end

    // consumer: 0 = always ready, 1 = random, 2 = pattern 1,0,0
    int rdy_mode = 0;
    initial begin
        int ph;
        ph = 0;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                1:       w_ready = 1'($urandom_range(0, 1));
                2:       begin w_ready = (ph % 3 == 0); ph++; end
                default: w_ready = 1'b1;
            endcase
        end
    end

    // issue one command; called just after a posedge
    task automatic cmd(int b, int l, bit spurious);
        int target;
        bit ok;
        target = n_done_seen + 1;
        base_addr = ADDR_W'(b); length = ADDR_W'(l); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (tb_reject(b, l)) begin
            @(posedge clk); #1;
            @(posedge clk); #1;
        end else begin
            ok = 0;
            for (int c = 0; c < 400; c++) begin
                if (n_done_seen >= target) begin ok = 1; break; end
                if (spurious && busy && ($urandom_range(0, 5) == 0)) begin
                    start = 1'b1;
                    base_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
                    length = ADDR_W'($urandom_range(0, 10));
                end else begin
                    start = 1'b0;
                end
                @(posedge clk); #1;
            end
            start = 1'b0;
            n_cmp++;
            if (!ok) begin
                n_bad++;
                $display("FAIL cmd_timeout: base %0d len %0d done not seen, required within 400 cycles", b, l);
            end
        end
    endtask

`ifdef WFETCH_BOUNDS_CHECK_EN
    task automatic rej(int b, int l);
        logic [ADDR_W-1:0] a0;
        a0 = sram_addr;
        base_addr = ADDR_W'(b); length = ADDR_W'(l); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("rej_err_pulse", err, 1);
        chk("rej_busy", busy, 0);
        @(posedge clk); #1;
        chk("rej_err_clear", err, 0);
        chk("rej_no_done", done, 0);
        chk("rej_no_read", sram_addr, a0);
    endtask
`endif

    initial begin
        #1000000;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4096; i++) sram[i] = DATA_W'($urandom);
        sram[10] = 16'd5;
        sram[11] = 16'hFFFD;
        sram[12] = 16'd7;
        sram[13] = 16'h8000;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_addr", sram_addr, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // base 10, length 4, always ready
        rdy_mode = 0;
        cmd(10, 4, 0);
        chk("t1_first_valid_cyc", first_valid_cyc, 3);
        chk("t1_last_cyc", last_cyc, 6);
        chk("t1_done_cyc", done_cyc, 7);
        chk("t1_count", got_q.size(), 4);
        if (got_q.size() == 4) begin
            chk("t1_w0", got_q[0], 5);
            chk("t1_w1", got_q[1], -3);
            chk("t1_w2", got_q[2], 7);
            chk("t1_w3", got_q[3], -32768);
        end

        // wrap at the end of the array
`ifdef WFETCH_BOUNDS_CHECK_EN
        rej(1998, 4);
        rej(1999, 2);
        rej(0, 2001);
        rej(2000, 0);
        cmd(1999, 1, 0);
        chk("b_one_addr", addr_log.size(), 1);
`else
        cmd(1998, 4, 0);
        chk("t2_naddr", addr_log.size(), 4);
        if (addr_log.size() == 4) begin
            chk("t2_a0", addr_log[0], 1998);
            chk("t2_a1", addr_log[1], 1999);
            chk("t2_a2", addr_log[2], 0);
            chk("t2_a3", addr_log[3], 1);
        end
        chk("t2_last_cyc", last_cyc, 6);
`endif

        // backpressure pattern 1,0,0
        rdy_mode = 2;
        cmd(100, 8, 0);
        chk("t3_count", got_q.size(), 8);
        for (int i = 0; i < 8 && i < got_q.size(); i++)
            chk("t3_word", got_q[i], int'($signed(sram[100 + i])));

        // zero length
        rdy_mode = 0;
        cmd(50, 0, 0);
        chk("t4_done_cyc", done_cyc, 1);
        chk("t4_no_valid", first_valid_cyc, -1);

        // reset in cycle 4 of a length-6 fetch
        base_addr = ADDR_W'(200); length = ADDR_W'(6); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("t5_valid_before_rst", w_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("t5_busy", busy, 0);
        chk("t5_valid", w_valid, 0);
        chk("t5_last", w_last, 0);
        chk("t5_addr", sram_addr, 0);
        chk("t5_data", w_data, 0);
        chk("t5_done", done, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        cmd(300, 3, 0);
        chk("t5_new_base", (addr_log.size() > 0) ? addr_log[0] : -1, 300);
        chk("t5_new_count", got_q.size(), 3);

        // randomized commands with random backpressure and starts while busy
        for (int k = 0; k < 40; k++) begin
            int b, l;
            rdy_mode = $urandom_range(0, 2);
            b = ($urandom_range(0, 3) == 0) ? $urandom_range(DEPTH - 8, DEPTH - 1)
                                            : $urandom_range(0, DEPTH - 1);
            l = $urandom_range(0, 10);
            if ($urandom_range(0, 7) == 0) sram[b] = DATA_W'($urandom);
            cmd(b, l, 1);
        end

        repeat (3) begin @(posedge clk); #1; end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
